// File: rtl/wishbone_gpio_bank_if.sv
// Wishbone classic slave bus bundle for the GPIO bank.
// Signal names keep the master/slave _i/_o suffixes as seen from the slave.
interface wishbone_gpio_bank_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int SELECT_WIDTH = 4
);
  localparam int SB = $clog2(SELECT_WIDTH);

  logic                    cyc_i;
  logic                    stb_i;
  logic                    we_i;
  logic [SB+4:0]           adr_i;
  logic [SELECT_WIDTH-1:0] sel_i;
  logic [DATA_WIDTH-1:0]   dat_i;
  logic [DATA_WIDTH-1:0]   dat_o;
  logic                    ack_o;
  logic                    err_o;
  logic                    rty_o;
  logic [1:0]              tgd_o;

  modport master (
    output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
    input  dat_o, ack_o, err_o, rty_o, tgd_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
    output dat_o, ack_o, err_o, rty_o, tgd_o
  );
endinterface

// File: rtl/wishbone_gpio_bank.sv
// Wishbone GPIO bank: output/direction registers with set/clear/toggle write modes,
// synchronized inputs, sticky edge-detect status and a level interrupt.
module wishbone_gpio_bank #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    SELECT_WIDTH = 4,
  parameter int                    SYNC_STAGES  = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_OUT    = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_DIR    = '0,
  parameter logic [1:0]            TGD          = 2'h0
) (
  input  logic                  clk_i,
  input  logic                  reset,
  wishbone_gpio_bank_if.slave   wb,
  input  logic [DATA_WIDTH-1:0] gpio_in,
  output logic [DATA_WIDTH-1:0] gpio_out,
  output logic [DATA_WIDTH-1:0] gpio_oe,
  output logic                  irq
);
  localparam int G  = DATA_WIDTH / SELECT_WIDTH;
  localparam int SB = $clog2(SELECT_WIDTH);

  logic [DATA_WIDTH-1:0] out_reg, dir_reg, rise_reg, fall_reg, stat_reg, mask_reg;
  logic [DATA_WIDTH-1:0] out_next, dir_next, rise_next, fall_next, stat_next, mask_next;
  logic [DATA_WIDTH-1:0] dat_reg;
  logic                  ack_reg, err_reg;
  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] sync_reg;
  logic [DATA_WIDTH-1:0] prev_reg;

  logic [DATA_WIDTH-1:0] sel_mask, wdat_masked, w1c, rd_data, pin_sync, pin_event;
  logic [1:0]            mode;
  logic [2:0]            reg_idx;
  logic                  accept, bad_access, do_write;

  // Expand granule selects into a per-bit write mask.
  for (genvar gi = 0; gi < SELECT_WIDTH; gi++) begin : g_sel
    assign sel_mask[gi*G +: G] = {G{wb.sel_i[gi]}};
  end

  assign mode        = wb.adr_i[SB+1:SB];
  assign reg_idx     = wb.adr_i[SB+4:SB+2];
  assign wdat_masked = wb.dat_i & sel_mask;

  // No pipelining: a new request is only taken once the previous termination has dropped.
  assign accept     = wb.cyc_i & wb.stb_i & ~ack_reg & ~err_reg;
  assign bad_access = (reg_idx == 3'd7) | (wb.we_i & (reg_idx == 3'd2));
  assign do_write   = accept & wb.we_i & ~bad_access;

  assign pin_sync  = sync_reg[SYNC_STAGES-1];
  assign pin_event = (~prev_reg & pin_sync & rise_reg) | (prev_reg & ~pin_sync & fall_reg);

  function automatic logic [DATA_WIDTH-1:0] rw_update(
    input logic [DATA_WIDTH-1:0] old,
    input logic [DATA_WIDTH-1:0] dm,
    input logic [DATA_WIDTH-1:0] msk,
    input logic [1:0]            m
  );
    case (m)
      2'd0:    rw_update = (old & ~msk) | dm;
      2'd1:    rw_update = old | dm;
      2'd2:    rw_update = old & ~dm;
      default: rw_update = old ^ dm;
    endcase
  endfunction

  always_comb begin
    rd_data = '0;
    case (reg_idx)
      3'd0:    rd_data = out_reg;
      3'd1:    rd_data = dir_reg;
      3'd2:    rd_data = pin_sync;
      3'd3:    rd_data = rise_reg;
      3'd4:    rd_data = fall_reg;
      3'd5:    rd_data = stat_reg;
      3'd6:    rd_data = mask_reg;
      default: rd_data = '0;
    endcase
  end

  always_comb begin
    out_next  = out_reg;
    dir_next  = dir_reg;
    rise_next = rise_reg;
    fall_next = fall_reg;
    mask_next = mask_reg;
    w1c       = '0;
    if (do_write) begin
      case (reg_idx)
        3'd0:    out_next  = rw_update(out_reg,  wdat_masked, sel_mask, mode);
        3'd1:    dir_next  = rw_update(dir_reg,  wdat_masked, sel_mask, mode);
        3'd3:    rise_next = rw_update(rise_reg, wdat_masked, sel_mask, mode);
        3'd4:    fall_next = rw_update(fall_reg, wdat_masked, sel_mask, mode);
        3'd5:    w1c       = wdat_masked;
        3'd6:    mask_next = rw_update(mask_reg, wdat_masked, sel_mask, mode);
        default: ;
      endcase
    end
    // A new event on the same edge as its clear leaves the bit set.
    stat_next = (stat_reg & ~w1c) | pin_event;
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      out_reg  <= RESET_OUT;
      dir_reg  <= RESET_DIR;
      rise_reg <= '0;
      fall_reg <= '0;
      stat_reg <= '0;
      mask_reg <= '0;
      dat_reg  <= '0;
      ack_reg  <= 1'b0;
      err_reg  <= 1'b0;
      sync_reg <= '0;
      prev_reg <= '0;
    end else begin
      out_reg  <= out_next;
      dir_reg  <= dir_next;
      rise_reg <= rise_next;
      fall_reg <= fall_next;
      stat_reg <= stat_next;
      mask_reg <= mask_next;
      ack_reg  <= accept & ~bad_access;
      err_reg  <= accept & bad_access;
      if (accept) dat_reg <= rd_data;
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], gpio_in};
      prev_reg <= pin_sync;
    end
  end

  assign wb.dat_o = dat_reg;
  assign wb.ack_o = ack_reg;
  assign wb.err_o = err_reg;
  assign wb.rty_o = 1'b0;
  assign wb.tgd_o = TGD;
  assign gpio_out = out_reg;
  assign gpio_oe  = dir_reg;
  assign irq      = |(stat_reg & mask_reg);
endmodule

// File: tb/tb_wishbone_gpio_bank.sv
// Randomized and directed checks of wishbone_gpio_bank against a register-level
// reference model that tracks pin samples as a delay queue.
module tb_wishbone_gpio_bank;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int SS = 2;

  logic          clk_i = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] gpio_in;
  logic [DW-1:0] gpio_out;
  logic [DW-1:0] gpio_oe;
  logic          irq;

  wishbone_gpio_bank_if #(.DATA_WIDTH(DW), .SELECT_WIDTH(SW)) wb ();

  wishbone_gpio_bank #(
    .DATA_WIDTH(DW), .SELECT_WIDTH(SW), .SYNC_STAGES(SS),
    .RESET_OUT(32'h0), .RESET_DIR(32'h0), .TGD(2'h0)
  ) dut (
    .clk_i(clk_i), .reset(reset), .wb(wb),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_out, m_dir, m_rise, m_fall, m_stat, m_mask, m_dat;
  bit          m_ack, m_err;
  logic [31:0] hist[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_out = 0; m_dir = 0; m_rise = 0; m_fall = 0; m_stat = 0; m_mask = 0; m_dat = 0;
    m_ack = 0; m_err = 0;
    hist = {};
    for (int i = 0; i <= SS; i++) hist.push_back(32'h0);
  endtask

  function automatic logic [31:0] rw_apply(input logic [31:0] old, input logic [31:0] d,
                                           input logic [3:0] sel, input logic [1:0] m);
    logic [31:0] r;
    logic [7:0]  o, x;
    r = old;
    for (int g = 0; g < 4; g++) begin
      if (sel[g]) begin
        o = old[g*8 +: 8];
        x = d[g*8 +: 8];
        case (m)
          2'd0: r[g*8 +: 8] = x;
          2'd1: r[g*8 +: 8] = o | x;
          2'd2: r[g*8 +: 8] = o & ~x;
          default: r[g*8 +: 8] = o ^ x;
        endcase
      end
    end
    return r;
  endfunction

  // Advance the model and the DUT by one clock edge, then compare every output.
  task automatic step();
    logic [31:0] sync, prev, ev, rd, selm;
    logic [2:0]  r;
    logic [1:0]  m;
    bit          acc, bad;
    r = wb.adr_i[6:4];
    m = wb.adr_i[3:2];
    sync = hist[SS-1];
    prev = hist[SS];
    ev = (~prev & sync & m_rise) | (prev & ~sync & m_fall);
    acc = wb.cyc_i && wb.stb_i && !m_ack && !m_err;
    bad = (r == 3'd7) || (wb.we_i && r == 3'd2);
    case (r)
      3'd0: rd = m_out;  3'd1: rd = m_dir;  3'd2: rd = sync;  3'd3: rd = m_rise;
      3'd4: rd = m_fall; 3'd5: rd = m_stat; 3'd6: rd = m_mask; default: rd = 0;
    endcase
    if (acc) m_dat = rd;
    if (acc && wb.we_i && !bad) begin
      case (r)
        3'd0: m_out  = rw_apply(m_out,  wb.dat_i, wb.sel_i, m);
        3'd1: m_dir  = rw_apply(m_dir,  wb.dat_i, wb.sel_i, m);
        3'd3: m_rise = rw_apply(m_rise, wb.dat_i, wb.sel_i, m);
        3'd4: m_fall = rw_apply(m_fall, wb.dat_i, wb.sel_i, m);
        3'd5: begin
          selm = rw_apply(32'h0, 32'hFFFF_FFFF, wb.sel_i, 2'd0);
          m_stat = m_stat & ~(wb.dat_i & selm);
        end
        3'd6: m_mask = rw_apply(m_mask, wb.dat_i, wb.sel_i, m);
        default: ;
      endcase
    end
    m_stat = m_stat | ev;
    m_ack = acc && !bad;
    m_err = acc && bad;
    hist.push_front(gpio_in);
    void'(hist.pop_back());
    @(posedge clk_i);
    #1;
    check_val("ack_o", 32'(wb.ack_o), 32'(m_ack));
    check_val("err_o", 32'(wb.err_o), 32'(m_err));
    check_val("dat_o", wb.dat_o, m_dat);
    check_val("gpio_out", gpio_out, m_out);
    check_val("gpio_oe", gpio_oe, m_dir);
    check_val("irq", 32'(irq), 32'(|(m_stat & m_mask)));
    check_val("rty_o", 32'(wb.rty_o), 32'h0);
    check_val("tgd_o", 32'(wb.tgd_o), 32'h0);
  endtask

  task automatic drive(input bit we, input logic [2:0] r, input logic [1:0] m,
                       input logic [3:0] sel, input logic [31:0] d);
    wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.we_i = we;
    wb.adr_i = {r, m, 2'b00}; wb.sel_i = sel; wb.dat_i = d;
  endtask

  task automatic idle();
    wb.cyc_i = 1'b0; wb.stb_i = 1'b0; wb.we_i = 1'b0;
  endtask

  task automatic xfer(input bit we, input logic [2:0] r, input logic [1:0] m,
                      input logic [3:0] sel, input logic [31:0] d,
                      output logic [31:0] rdata, output logic ack, output logic err);
    drive(we, r, m, sel, d);
    step();
    rdata = wb.dat_o; ack = wb.ack_o; err = wb.err_o;
    idle();
    step();
    $display("xfer we=%0d R=%0d M=%0d sel=%b d=0x%08h -> dat=0x%08h ack=%0d err=%0d",
             we, r, m, sel, d, rdata, ack, err);
  endtask

  logic [31:0] rd;
  logic        ak, er;

  initial begin
    gpio_in = '0;
    wb.adr_i = '0; wb.sel_i = '0; wb.dat_i = '0;
    idle();
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    check_val("rst_ack", 32'(wb.ack_o), 32'h0);
    check_val("rst_err", 32'(wb.err_o), 32'h0);
    check_val("rst_dat", wb.dat_o, 32'h0);
    check_val("rst_out", gpio_out, 32'h0);
    check_val("rst_oe", gpio_oe, 32'h0);
    check_val("rst_irq", 32'(irq), 32'h0);
    reset = 1'b0;
    step();

    // Write modes on OUT
    xfer(1, 0, 0, 4'hF, 32'hFFFF_0000, rd, ak, er);
    check_val("w_load_ack", 32'(ak), 32'h1);
    xfer(1, 0, 1, 4'hF, 32'h0000_00FF, rd, ak, er);
    xfer(1, 0, 2, 4'b0100, 32'h00FF_0000, rd, ak, er);
    xfer(0, 0, 0, 4'hF, 32'h0, rd, ak, er);
    check_val("out_modes", rd, 32'hFF00_00FF);
    xfer(1, 0, 0, 4'hF, 32'hA5A5_A5A5, rd, ak, er);
    xfer(1, 0, 3, 4'b0001, 32'hFFFF_FFFF, rd, ak, er);
    xfer(0, 0, 0, 4'hF, 32'h0, rd, ak, er);
    check_val("out_toggle", rd, 32'hA5A5_A55A);

    // Rising edge latency and W1C
    xfer(1, 3, 0, 4'hF, 32'h1, rd, ak, er);
    xfer(1, 6, 0, 4'hF, 32'h1, rd, ak, er);
    gpio_in[0] = 1'b1;
    step();
    check_val("rise_lat1", 32'(irq), 32'h0);
    step();
    check_val("rise_lat2", 32'(irq), 32'h0);
    step();
    check_val("rise_lat3", 32'(irq), 32'h1);
    xfer(0, 5, 0, 4'hF, 32'h0, rd, ak, er);
    check_val("stat_rise", rd, 32'h1);
    xfer(1, 5, 0, 4'hF, 32'h1, rd, ak, er);
    check_val("w1c_irq", 32'(irq), 32'h0);

    // Error terminations leave state untouched
    xfer(1, 2, 0, 4'hF, 32'h1234_5678, rd, ak, er);
    check_val("err_wr_in_err", 32'(er), 32'h1);
    check_val("err_wr_in_ack", 32'(ak), 32'h0);
    xfer(0, 7, 0, 4'hF, 32'h0, rd, ak, er);
    check_val("err_rd7_err", 32'(er), 32'h1);
    check_val("err_rd7_ack", 32'(ak), 32'h0);
    xfer(1, 7, 0, 4'hF, 32'hFFFF_FFFF, rd, ak, er);
    xfer(0, 0, 0, 4'hF, 32'h0, rd, ak, er);
    check_val("err_no_change", rd, 32'hA5A5_A55A);

    // Falling event on the same edge as its W1C: set wins
    xfer(1, 4, 0, 4'hF, 32'h1, rd, ak, er);
    gpio_in[0] = 1'b0;
    step();
    step();
    drive(1, 5, 0, 4'hF, 32'h1);
    step();
    idle();
    step();
    xfer(0, 5, 0, 4'hF, 32'h0, rd, ak, er);
    check_val("set_wins", rd & 32'h1, 32'h1);

    // Randomized traffic, including held strobes and abandoned cycles
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) gpio_in = $urandom();
      if ($urandom_range(0, 3) == 0) begin
        idle();
        step();
      end else begin
        drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
              4'($urandom_range(0, 15)), $urandom());
        if ($urandom_range(0, 7) == 0) wb.cyc_i = 1'b0;
        $display("rand %0d we=%0d adr=0x%02h sel=%b d=0x%08h cyc=%0d",
                 i, wb.we_i, wb.adr_i, wb.sel_i, wb.dat_i, wb.cyc_i);
        repeat ($urandom_range(1, 3)) step();
        idle();
        step();
      end
    end

    // Reset asserted right at the acceptance edge: no termination, reset state
    xfer(1, 1, 0, 4'hF, 32'h0F0F_0F0F, rd, ak, er);
    drive(1, 0, 0, 4'hF, 32'h1234_5678);
    @(posedge clk_i);
    reset = 1'b1;
    model_reset();
    idle();
    #1;
    check_val("rst_mid_ack", 32'(wb.ack_o), 32'h0);
    check_val("rst_mid_out", gpio_out, 32'h0);
    check_val("rst_mid_oe", gpio_oe, 32'h0);
    repeat (2) @(posedge clk_i);
    #1;
    check_val("rst_mid_ack2", 32'(wb.ack_o), 32'h0);
    reset = 1'b0;
    step();
    xfer(0, 0, 0, 4'hF, 32'h0, rd, ak, er);
    check_val("rst_out_rd", rd, 32'h0);
    xfer(0, 5, 0, 4'hF, 32'h0, rd, ak, er);
    check_val("rst_stat_rd", rd, 32'h0);
    xfer(0, 6, 0, 4'hF, 32'h0, rd, ak, er);
    check_val("rst_mask_rd", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
